// File: rtl/scan_digit_mux.sv
// Time-multiplexed seven-segment digit scanner with per-digit masking,
// leading-zero blanking, frame-coherent input snapshot and guard interval.
module scan_digit_mux #(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned DW       = 4,
  parameter int unsigned DIV      = 100000,
  parameter int unsigned GUARD    = 0,
  localparam int unsigned IW      = $clog2(N_DIGITS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [N_DIGITS*DW-1:0] din,
  input  logic [N_DIGITS-1:0]    dig_mask,
  input  logic                   blank_lz,
  output logic [N_DIGITS-1:0]    an_n,
  output logic [DW-1:0]          dig_val,
  output logic [IW-1:0]          dig_idx,
  output logic                   blank,
  output logic                   frame_start
);

  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned AW = N_DIGITS * DW;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(N_DIGITS - 1);

  logic [PW-1:0]       p;
  logic [PW-1:0]       p_nxt;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_nxt;
  logic [AW-1:0]       din_sh;
  logic [N_DIGITS-1:0] mask_sh;
  logic                lz_sh;
  logic                load_pending;

  logic                load_c;
  logic                update_c;
  logic [AW-1:0]       src_din;
  logic [N_DIGITS-1:0] src_mask;
  logic                src_lz;
  logic [DW-1:0]       val_nxt;
  logic                blank_nxt;
  logic                guard_ok;
  logic [N_DIGITS-1:0] an_nxt;

  // Dark if masked, or if LZ blanking is on and no lit non-zero digit sits at or above i.
  function automatic logic digit_blank(
    input logic [AW-1:0]       d,
    input logic [N_DIGITS-1:0] m,
    input logic                lz,
    input logic [IW-1:0]       i
  );
    logic live_above;
    live_above = 1'b0;
    for (int j = 0; j < int'(N_DIGITS); j++) begin
      if (IW'(j) >= i && m[j] && d[j*DW +: DW] != '0) live_above = 1'b1;
    end
    return !m[i] || (lz && i != '0 && !live_above);
  endfunction

  // Prescaler / digit index sequencing and frame-load decision.
  always_comb begin
    p_nxt    = p;
    idx_nxt  = idx;
    load_c   = 1'b0;
    update_c = 1'b0;
    if (en) begin
      if (load_pending) begin
        load_c   = 1'b1;
        update_c = 1'b1;
        idx_nxt  = '0;
        p_nxt    = '0;
      end else if (p == P_LAST) begin
        update_c = 1'b1;
        p_nxt    = '0;
        if (idx == I_LAST) begin
          idx_nxt = '0;
          load_c  = 1'b1;
        end else begin
          idx_nxt = idx + IW'(1);
        end
      end else begin
        p_nxt = p + PW'(1);
      end
    end
  end

  // The digit presented at a frame load is taken from the live inputs, not the stale shadow.
  always_comb begin
    src_din   = load_c ? din : din_sh;
    src_mask  = load_c ? dig_mask : mask_sh;
    src_lz    = load_c ? blank_lz : lz_sh;
    val_nxt   = src_din[idx_nxt*DW +: DW];
    blank_nxt = update_c ? digit_blank(src_din, src_mask, src_lz, idx_nxt) : blank;
    an_nxt    = '1;
    if (en && !blank_nxt && guard_ok) an_nxt[idx_nxt] = 1'b0;
  end

  generate
    if (GUARD == 0) begin : g_no_guard
      assign guard_ok = 1'b1;
    end else begin : g_guard
      assign guard_ok = (p_nxt >= PW'(GUARD));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p            <= '0;
      idx          <= '0;
      din_sh       <= '0;
      mask_sh      <= '0;
      lz_sh        <= 1'b0;
      load_pending <= 1'b1;
      an_n         <= '1;
      dig_val      <= '0;
      dig_idx      <= '0;
      blank        <= 1'b1;
      frame_start  <= 1'b0;
    end else begin
      p           <= p_nxt;
      idx         <= idx_nxt;
      an_n        <= an_nxt;
      frame_start <= load_c;
      if (load_c) begin
        din_sh       <= din;
        mask_sh      <= dig_mask;
        lz_sh        <= blank_lz;
        load_pending <= 1'b0;
      end
      if (update_c) begin
        dig_idx <= idx_nxt;
        dig_val <= val_nxt;
        blank   <= blank_nxt;
      end
    end
  end

endmodule
